// File: rtl/hms_set_seq.sv
`timescale 1ns/1ps
// hms_set_seq: programs hours/minutes/seconds into the timekeeper through its
// load/addr/din port, reads the live time back to confirm the write, rewrites
// on mismatch and reports done/err/err_code/retries.
module hms_set_seq #(
    parameter int VERIFY_DLY = 2,
    parameter int MAX_RETRY  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [4:0] hrs_in,
    input  logic [5:0] min_in,
    input  logic [5:0] sec_in,
    input  logic [4:0] hrs,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    output logic       load,
    output logic [1:0] addr,
    output logic [5:0] din,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [1:0] retries
);

    localparam int VC_W = (VERIFY_DLY > 1) ? $clog2(VERIFY_DLY) : 1;
    localparam logic [VC_W-1:0] VC_LAST = VC_W'(VERIFY_DLY - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_WR_H, S_GAP_H, S_WR_M, S_GAP_M,
        S_WR_S, S_GAP_S, S_VERIFY, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_hrs_l;
    logic [5:0]      r_min_l;
    logic [5:0]      r_sec_l;
    logic [VC_W-1:0] r_vcnt;
    logic [1:0]      r_rcnt;

    logic            w_range_bad;
    logic            w_vlast;
    logic            w_match;
    logic            w_can_retry;
    logic            w_rcnt_inc;
    logic [1:0]      w_code_nxt;
    logic            w_load_nxt;
    logic [1:0]      w_addr_nxt;
    logic [5:0]      w_din_nxt;
    logic            w_busy_nxt;

    // Seconds value one tick after v, wrapping 59 -> 0.
    function automatic logic [5:0] sec_plus1(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    // Retry counter increment that sticks at 3.
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

    assign w_range_bad = (r_hrs_l > 5'd23) || (r_min_l > 6'd59) || (r_sec_l > 6'd59);
    assign w_vlast     = (r_vcnt == VC_LAST);
    // A seconds tick between write and readback is tolerated; a carry into
    // minutes/hours is not, since the written minute/hour would be lost.
    assign w_match     = (hrs == r_hrs_l) && (min == r_min_l) &&
                         ((sec == r_sec_l) || (sec == sec_plus1(r_sec_l)));
    assign w_can_retry = (int'(r_rcnt) < MAX_RETRY);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, completion code and the output values of the next state.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = 2'b00;
        w_rcnt_inc  = 1'b0;
        w_load_nxt  = 1'b0;
        w_addr_nxt  = 2'd0;
        w_din_nxt   = 6'd0;
        case (r_state)
            S_IDLE:   if (req) w_state_nxt = S_CHECK;
            S_CHECK: begin
                if (w_range_bad) begin
                    w_state_nxt = S_DONE;
                    w_code_nxt  = 2'b01;
                end else begin
                    w_state_nxt = S_WR_H;
                end
            end
            S_WR_H:   w_state_nxt = S_GAP_H;
            S_GAP_H:  w_state_nxt = S_WR_M;
            S_WR_M:   w_state_nxt = S_GAP_M;
            S_GAP_M:  w_state_nxt = S_WR_S;
            S_WR_S:   w_state_nxt = S_GAP_S;
            S_GAP_S:  w_state_nxt = S_VERIFY;
            S_VERIFY: begin
                if (w_vlast) begin
                    if (w_match) begin
                        w_state_nxt = S_DONE;
                    end else if (w_can_retry) begin
                        w_state_nxt = S_WR_H;
                        w_rcnt_inc  = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                        w_code_nxt  = 2'b10;
                    end
                end
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase

        case (w_state_nxt)
            S_WR_H: begin
                w_load_nxt = 1'b1;
                w_addr_nxt = 2'd0;
                w_din_nxt  = {1'b0, r_hrs_l};
            end
            S_WR_M: begin
                w_load_nxt = 1'b1;
                w_addr_nxt = 2'd1;
                w_din_nxt  = r_min_l;
            end
            S_WR_S: begin
                w_load_nxt = 1'b1;
                w_addr_nxt = 2'd2;
                w_din_nxt  = r_sec_l;
            end
            default: begin
                w_load_nxt = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    end

    // Registered outputs, verify-delay counter and retry counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            load     <= 1'b0;
            addr     <= 2'd0;
            din      <= 6'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            retries  <= 2'd0;
            r_vcnt   <= '0;
            r_rcnt   <= 2'd0;
        end else begin
            load <= w_load_nxt;
            addr <= w_addr_nxt;
            din  <= w_din_nxt;
            busy <= w_busy_nxt;
            done <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) begin
                err      <= (w_code_nxt != 2'b00);
                err_code <= w_code_nxt;
                retries  <= r_rcnt;
            end
            if (r_state != S_VERIFY) begin
                r_vcnt <= '0;
            end else if (!w_vlast) begin
                r_vcnt <= r_vcnt + VC_W'(1);
            end
            if ((r_state == S_IDLE) && req) begin
                r_rcnt <= 2'd0;
            end else if (w_rcnt_inc) begin
                r_rcnt <= sat_inc2(r_rcnt);
            end
        end
    end

    // Capture the requested time at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && req) begin
            r_hrs_l <= hrs_in;
            r_min_l <= min_in;
            r_sec_l <= sec_in;
        end
    end

endmodule

// File: tb/tb_hms_set_seq.sv
`timescale 1ns/1ps
module tb_hms_set_seq;
    localparam int VD = 2;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [4:0] hrs_in = '0;
    logic [5:0] min_in = '0;
    logic [5:0] sec_in = '0;
    logic [4:0] hrs;
    logic [5:0] min;
    logic [5:0] sec;
    logic       load;
    logic [1:0] addr;
    logic [5:0] din;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [1:0] retries;

    hms_set_seq #(.VERIFY_DLY(VD), .MAX_RETRY(MR)) dut (
        .clk(clk), .rst(rst), .req(req),
        .hrs_in(hrs_in), .min_in(min_in), .sec_in(sec_in),
        .hrs(hrs), .min(min), .sec(sec),
        .load(load), .addr(addr), .din(din),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .retries(retries)
    );

    always #5 clk = ~clk;

    // ---------------- timekeeper model (readback source) ----------------
    logic [4:0] tk_h = '0;
    logic [5:0] tk_m = '0;
    logic [5:0] tk_s = '0;
    logic [5:0] tk_ctr = '0;
    int         tk_nload = 0;
    int         ign_until = 0;
    bit         tk_stuck = 1'b0;
    bit         tick_en = 1'b0;

    always @(posedge clk) begin
        tk_ctr <= tk_ctr + 6'd1;
        if (load === 1'b1) begin
            tk_nload <= tk_nload + 1;
            if (tk_nload >= ign_until) begin
                case (addr)
                    2'd0: tk_h <= din[4:0];
                    2'd1: tk_m <= din;
                    2'd2: tk_s <= din;
                    default: ;
                endcase
            end
        end else if (tick_en && tk_ctr == 6'd63) begin
            if (tk_s >= 6'd59) begin
                tk_s <= 6'd0;
                if (tk_m >= 6'd59) begin
                    tk_m <= 6'd0;
                    tk_h <= (tk_h >= 5'd23) ? 5'd0 : tk_h + 5'd1;
                end else begin
                    tk_m <= tk_m + 6'd1;
                end
            end else begin
                tk_s <= tk_s + 6'd1;
            end
        end
    end

    assign hrs = tk_stuck ? 5'd0 : tk_h;
    assign min = tk_stuck ? 6'd0 : tk_m;
    assign sec = tk_stuck ? 6'd0 : tk_s;

    // ---------------- behavioural reference ----------------
    // A request is described by its acceptance-relative cycle number d:
    // d=1 check, then write attempts of 6+VD cycles starting at m_seg, with
    // strobes at offsets 0/2/4 and the readback decision at the end.
    bit         m_started = 1'b0;
    bit         m_act = 1'b0;
    bit         m_bad = 1'b0;
    int         m_d = 0;
    int         m_seg = 0;
    int         m_done_d = -1;
    int         m_att = 0;
    logic [4:0] l_h = '0;
    logic [5:0] l_m = '0;
    logic [5:0] l_s = '0;
    bit         m_err = 1'b0;
    logic [1:0] m_code = '0;
    logic [1:0] m_ret = '0;
    logic [15:0] exp_vec = '0;

    always @(posedge clk) begin : model
        int   off;
        int   fin;
        bit   pass;
        logic e_load, e_busy, e_done;
        logic [1:0] e_addr;
        logic [5:0] e_din;
        fin = -1;
        m_started = 1'b1;
        if (rst) begin
            m_act = 1'b0; m_err = 1'b0; m_code = 2'd0; m_ret = 2'd0;
        end else if (m_act && m_d == m_done_d) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (req) begin
                m_act = 1'b1; m_d = 1; m_att = 0; m_seg = 2; m_done_d = -1;
                l_h = hrs_in; l_m = min_in; l_s = sec_in;
                m_bad = (hrs_in > 23) || (min_in > 59) || (sec_in > 59);
            end
        end else begin
            m_d++;
            if (m_bad) begin
                if (m_d == 2) fin = 1;
            end else if (m_d == m_seg + 6 + VD) begin
                pass = (int'(hrs) == int'(l_h)) && (int'(min) == int'(l_m)) &&
                       ((int'(sec) == int'(l_s)) || (int'(sec) == (int'(l_s) + 1) % 60));
                if (pass) fin = 0;
                else if (m_att < MR) begin m_att++; m_seg = m_d; end
                else fin = 2;
            end
        end
        if (fin >= 0) begin
            m_done_d = m_d;
            m_err = (fin != 0);
            m_code = 2'(fin);
            m_ret = 2'((m_att > 3) ? 3 : m_att);
        end
        off = m_d - m_seg;
        e_busy = m_act && (m_d != m_done_d);
        e_done = m_act && (m_d == m_done_d);
        e_load = e_busy && !m_bad && (off == 0 || off == 2 || off == 4);
        e_addr = e_load ? 2'(off / 2) : 2'd0;
        e_din  = !e_load ? 6'd0 : (off == 0) ? {1'b0, l_h} : (off == 2) ? l_m : l_s;
        exp_vec = {e_load, e_addr, e_din, e_busy, e_done, m_err, m_code, m_ret};
    end

    logic [15:0] act_vec;
    assign act_vec = {load, addr, din, busy, done, err, err_code, retries};

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int ld_cyc[10];
    logic [1:0] ld_addr[10];
    logic [5:0] ld_din[10];
    int n_ld = 0;
    int done_at = -1;
    logic [4:0] fin_res = '0;
    logic [5:0] rb_h = '0, rb_m = '0, rb_s = '0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, expv);
        end
    endtask

    // Issue one request and log strobes and the done pulse by cycle number.
    task automatic do_req(input int h, input int m, input int s, input bit wiggle);
        @(negedge clk);
        hrs_in = 5'(h); min_in = 6'(m); sec_in = 6'(s); req = 1'b1;
        n_ld = 0; done_at = -1;
        for (int n = 1; n <= 60 && done_at < 0; n++) begin
            @(posedge clk); #1;
            if (load === 1'b1) begin
                if (n_ld < 10) begin
                    ld_cyc[n_ld] = n; ld_addr[n_ld] = addr; ld_din[n_ld] = din;
                end
                n_ld++;
            end
            if (done === 1'b1) begin
                done_at = n;
                fin_res = {err, err_code, retries};
                rb_h = 6'(hrs); rb_m = min; rb_s = sec;
            end
            @(negedge clk);
            if (done_at >= 0 || !wiggle) begin
                req = 1'b0;
            end else begin
                req = 1'($urandom);
                hrs_in = 5'($urandom); min_in = 6'($urandom); sec_in = 6'($urandom);
            end
        end
        check("done_seen", int'(done_at >= 0), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (m_started) begin
                    n_cmp++;
                    if (act_vec !== exp_vec) begin
                        n_bad++;
                        $display("FAIL cycle_outputs @%0t got %h want %h (load,addr,din,busy,done,err,code,retries)",
                                 $time, act_vec, exp_vec);
                    end
                end
            end
        join_none

        // Reset, then idle with req low.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_ld = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (load !== 1'b0) n_ld++;
        end
        check("idle_loads", n_ld, 0);
        check("idle_outputs", int'(act_vec), 0);

        // Nominal write into a working timekeeper.
        tick_en = 1'b1;
        do_req(13, 27, 45, 1'b0);
        check("nom_done_cycle", done_at, 10);
        check("nom_nloads", n_ld, 3);
        check("nom_ld0", ld_cyc[0] * 1000 + int'(ld_addr[0]) * 100 + int'(ld_din[0]), 2013);
        check("nom_ld1", ld_cyc[1] * 1000 + int'(ld_addr[1]) * 100 + int'(ld_din[1]), 4127);
        check("nom_ld2", ld_cyc[2] * 1000 + int'(ld_addr[2]) * 100 + int'(ld_din[2]), 6245);
        check("nom_result", int'(fin_res), 0);
        check("nom_readback_hm", int'(rb_h) * 100 + int'(rb_m), 1327);
        check("nom_readback_s", int'(rb_s == 45 || rb_s == 46), 1);

        // Range errors.
        do_req(24, 0, 0, 1'b0);
        check("rng_h_done_cycle", done_at, 2);
        check("rng_h_nloads", n_ld, 0);
        check("rng_h_result", int'(fin_res), 5'b10100);
        do_req(10, 60, 0, 1'b0);
        check("rng_m_done_cycle", done_at, 2);
        check("rng_m_nloads", n_ld, 0);
        check("rng_m_result", int'(fin_res), 5'b10100);

        // Readback stuck at zero: all retries used.
        tk_stuck = 1'b1;
        do_req(1, 2, 3, 1'b0);
        tk_stuck = 1'b0;
        check("stuck_done_cycle", done_at, 26);
        check("stuck_nloads", n_ld, 9);
        check("stuck_ld6_cycle", ld_cyc[6], 18);
        check("stuck_result", int'(fin_res), 5'b11010);

        // First write triplet lost; req and inputs wiggle while busy.
        ign_until = tk_nload + 3;
        do_req(7, 8, 9, 1'b1);
        check("retry_done_cycle", done_at, 18);
        check("retry_nloads", n_ld, 6);
        check("retry_ld3", ld_cyc[3] * 100 + int'(ld_din[3]), 1007);
        check("retry_ld4_din", int'(ld_din[4]), 8);
        check("retry_ld5_din", int'(ld_din[5]), 9);
        check("retry_result", int'(fin_res), 5'b00001);

        // Reset between the hours and minutes strobes.
        @(negedge clk);
        hrs_in = 5'd5; min_in = 6'd6; sec_in = 6'd7; req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); req = 1'b0;
        @(posedge clk); #1;
        check("rst_wrh_load", int'(load), 1);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_after_load", int'(load), 0);
        check("rst_after_busy", int'(busy), 0);
        check("rst_after_held", int'({done, err, err_code, retries}), 0);
        @(negedge clk); rst = 1'b0;
        n_ld = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (load !== 1'b0) n_ld++;
        end
        check("rst_no_strobes", n_ld, 0);
        do_req(20, 30, 40, 1'b0);
        check("post_rst_done_cycle", done_at, 10);
        check("post_rst_result", int'(fin_res), 0);

        // Randomized traffic against the reference.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            req = ($urandom_range(0, 3) == 0);
            hrs_in = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            min_in = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
            sec_in = ($urandom_range(0, 5) == 0) ? 6'd59 :
                     ($urandom_range(0, 9) == 0) ? 6'($urandom_range(60, 63)) : 6'($urandom_range(0, 59));
            if ($urandom_range(0, 99) == 0) tk_stuck = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) ign_until = tk_nload + 3;
        end
        @(negedge clk);
        rst = 1'b0; req = 1'b0; tk_stuck = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
